instr_encoder: RTL and testbench

INSTR_ENCODER -- requirements
Module: instr_encoder

---
 rtl/instr_encoder.sv | 84 ++++++++
 tb/tb_instr_encoder.sv | 248 ++++++++++++++++++++++++
 2 files changed

// File: rtl/instr_encoder.sv
// instr_encoder: encodes MIPS-style R/I/J instructions and writes them sequentially
// into instruction memory through a single-word handshake port.
module instr_encoder #(
   parameter logic [31:0] BASE_ADDR = 32'h0000_0000,
   parameter int          MAX_WORDS = 64
) (
   input  logic        clk,
   input  logic        reset,
   input  logic        in_valid,
   output logic        in_ready,
   input  logic [3:0]  in_kind,
   input  logic [4:0]  in_rs,
   input  logic [4:0]  in_rt,
   input  logic [4:0]  in_rd,
   input  logic [15:0] in_imm,
   input  logic [25:0] in_target,
   input  logic        clear,
   output logic        mem_we,
   output logic [31:0] mem_addr,
   output logic [31:0] mem_wdata,
   input  logic        mem_ready,
   output logic [7:0]  count,
   output logic        full,
   output logic        err
);
   typedef enum logic {IDLE, SEND} state_t;
   state_t state, state_nx;
   logic accept, legal;
   logic [5:0] code;
   logic [31:0] word;
   assign full = count == 8'(MAX_WORDS);
   assign in_ready = state == IDLE && !full && !clear;
   assign accept = in_valid && in_ready;
   assign legal = in_kind < 4'd12;
   // kinds 0-4 carry a funct code, 5-10 an I-type opcode, 11 the J-type opcode
   always_comb begin
      case (in_kind)
         4'd0:    code = 6'h20;
         4'd1:    code = 6'h22;
         4'd2:    code = 6'h24;
         4'd3:    code = 6'h25;
         4'd4:    code = 6'h2A;
         4'd5:    code = 6'h23;
         4'd6:    code = 6'h2B;
         4'd7:    code = 6'h04;
         4'd8:    code = 6'h05;
         4'd9:    code = 6'h08;
         4'd10:   code = 6'h0D;
         4'd11:   code = 6'h02;
         default: code = 6'h00;
      endcase
   end
   assign word = in_kind < 4'd5  ? {6'b0, in_rs, in_rt, in_rd, 5'b0, code} :
                 in_kind < 4'd11 ? {code, in_rs, in_rt, in_imm} : {code, in_target};
   always_ff @(posedge clk) begin
      if (!reset) state <= IDLE;
      else        state <= state_nx;
   end
   always_comb begin
      state_nx = state == IDLE ? (accept && legal ? SEND : IDLE) : (mem_ready ? IDLE : SEND);
   end
   always_comb begin
      mem_we = state == SEND;
   end
   always_ff @(posedge clk) begin
      if (!reset) begin
         mem_addr  <= BASE_ADDR;
         mem_wdata <= '0;
         count     <= '0;
         err       <= 1'b0;
      end else begin
         if (accept && legal) begin
            mem_wdata <= word;
            mem_addr  <= BASE_ADDR + {22'b0, count, 2'b00};
         end
         if (accept && !legal) err <= 1'b1;
         if (state == IDLE && clear) begin
            count <= '0;
            err   <= 1'b0;
         end
         if (state == SEND && mem_ready) count <= count + 8'd1;
      end
   end
endmodule

// File: tb/tb_instr_encoder.sv
// tb_instr_encoder: randomized and directed checks of instr_encoder against an
// arithmetic encoding model and a transaction-level count/err model.
module tb_instr_encoder;
   logic        clk = 1'b0;
   logic        reset = 1'b0;
   logic        in_valid = 1'b0;
   logic [3:0]  in_kind = '0;
   logic [4:0]  in_rs = '0, in_rt = '0, in_rd = '0;
   logic [15:0] in_imm = '0;
   logic [25:0] in_target = '0;
   logic        clear = 1'b0;
   logic        mem_ready = 1'b0;
   logic        in_ready, mem_we, full, err;
   logic [31:0] mem_addr, mem_wdata;
   logic [7:0]  count;
   logic        s_in_ready, s_mem_we, s_full, s_err;
   logic [31:0] s_mem_addr, s_mem_wdata;
   logic [7:0]  s_count;
   int vectors = 0;
   int miscompares = 0;
   int exp_count = 0;
   logic exp_err = 1'b0;

   always #5 clk = ~clk;

   instr_encoder dut (
      .clk(clk), .reset(reset), .in_valid(in_valid), .in_ready(in_ready),
      .in_kind(in_kind), .in_rs(in_rs), .in_rt(in_rt), .in_rd(in_rd),
      .in_imm(in_imm), .in_target(in_target), .clear(clear),
      .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
      .mem_ready(mem_ready), .count(count), .full(full), .err(err)
   );

   instr_encoder #(.MAX_WORDS(2)) dut_s (
      .clk(clk), .reset(reset), .in_valid(in_valid), .in_ready(s_in_ready),
      .in_kind(in_kind), .in_rs(in_rs), .in_rt(in_rt), .in_rd(in_rd),
      .in_imm(in_imm), .in_target(in_target), .clear(clear),
      .mem_we(s_mem_we), .mem_addr(s_mem_addr), .mem_wdata(s_mem_wdata),
      .mem_ready(mem_ready), .count(s_count), .full(s_full), .err(s_err)
   );

   function automatic logic [31:0] model_word(input int k, input logic [31:0] rs, rt, rd, imm, tg);
      int codes[12] = '{32'h20, 32'h22, 32'h24, 32'h25, 32'h2A, 32'h23, 32'h2B, 32'h04, 32'h05, 32'h08, 32'h0D, 32'h02};
      logic [31:0] c;
      c = codes[k];
      if (k < 5) return rs * 32'h20_0000 + rt * 32'h1_0000 + rd * 32'h800 + c;
      if (k < 11) return c * 32'h400_0000 + rs * 32'h20_0000 + rt * 32'h1_0000 + imm;
      return c * 32'h400_0000 + tg;
   endfunction

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   // one request end to end; stall = cycles mem_ready stays low, clr = assert clear while stalled
   task automatic do_req(input int k, input logic [4:0] rs, rt, rd, input logic [15:0] imm,
                         input logic [25:0] tg, input int stall, input bit clr);
      logic [31:0] w, a;
      a = 32'(exp_count * 4);
      in_kind = 4'(k); in_rs = rs; in_rt = rt; in_rd = rd; in_imm = imm; in_target = tg;
      in_valid = 1'b1; mem_ready = 1'b0;
      #1;
      vectors++;
      if (in_ready !== 1'b1) begin miscompares++; $display("FAIL in_ready_idle: got %b expected 1", in_ready); end
      tick();
      in_valid = 1'b0;
      if (k >= 12) begin
         exp_err = 1'b1;
         vectors += 3;
         if (mem_we !== 1'b0) begin miscompares++; $display("FAIL illegal_we: got %b expected 0", mem_we); end
         if (err !== 1'b1) begin miscompares++; $display("FAIL illegal_err: got %b expected 1", err); end
         if (count !== 8'(exp_count)) begin miscompares++; $display("FAIL illegal_count: got %0d expected %0d", count, exp_count); end
         return;
      end
      w = model_word(k, 32'(rs), 32'(rt), 32'(rd), 32'(imm), 32'(tg));
      vectors += 3;
      if (mem_we !== 1'b1) begin miscompares++; $display("FAIL send_we: got %b expected 1", mem_we); end
      if (mem_addr !== a) begin miscompares++; $display("FAIL send_addr: got %h expected %h", mem_addr, a); end
      if (mem_wdata !== w) begin miscompares++; $display("FAIL send_wdata kind %0d: got %h expected %h", k, mem_wdata, w); end
      for (int i = 0; i < stall; i++) begin
         clear = clr;
         tick();
         vectors += 4;
         if (mem_we !== 1'b1) begin miscompares++; $display("FAIL stall_we: got %b expected 1", mem_we); end
         if (mem_addr !== a || mem_wdata !== w) begin miscompares++; $display("FAIL stall_hold: got %h/%h expected %h/%h", mem_addr, mem_wdata, a, w); end
         if (in_ready !== 1'b0) begin miscompares++; $display("FAIL stall_ready: got %b expected 0", in_ready); end
         if (count !== 8'(exp_count)) begin miscompares++; $display("FAIL stall_count: got %0d expected %0d", count, exp_count); end
      end
      clear = 1'b0;
      mem_ready = 1'b1;
      tick();
      mem_ready = 1'b0;
      exp_count++;
      vectors += 5;
      if (mem_we !== 1'b0) begin miscompares++; $display("FAIL done_we: got %b expected 0", mem_we); end
      if (count !== 8'(exp_count)) begin miscompares++; $display("FAIL done_count: got %0d expected %0d", count, exp_count); end
      if (mem_wdata !== w) begin miscompares++; $display("FAIL done_wdata_kept: got %h expected %h", mem_wdata, w); end
      if (err !== exp_err) begin miscompares++; $display("FAIL done_err: got %b expected %b", err, exp_err); end
      if (in_ready !== 1'b1) begin miscompares++; $display("FAIL done_ready: got %b expected 1", in_ready); end
   endtask

   task automatic pulse_clear();
      clear = 1'b1;
      tick();
      clear = 1'b0;
      exp_count = 0;
      exp_err = 1'b0;
   endtask

   task automatic test_reset();
      reset = 1'b0;
      tick();
      tick();
      reset = 1'b1;
      #1;
      vectors += 7;
      if (mem_we !== 1'b0) begin miscompares++; $display("FAIL reset_we: got %b expected 0", mem_we); end
      if (mem_addr !== 32'h0) begin miscompares++; $display("FAIL reset_addr: got %h expected 0", mem_addr); end
      if (mem_wdata !== 32'h0) begin miscompares++; $display("FAIL reset_wdata: got %h expected 0", mem_wdata); end
      if (count !== 8'd0) begin miscompares++; $display("FAIL reset_count: got %0d expected 0", count); end
      if (full !== 1'b0) begin miscompares++; $display("FAIL reset_full: got %b expected 0", full); end
      if (err !== 1'b0) begin miscompares++; $display("FAIL reset_err: got %b expected 0", err); end
      if (in_ready !== 1'b1) begin miscompares++; $display("FAIL reset_ready: got %b expected 1", in_ready); end
   endtask

   task automatic test_add();
      do_req(0, 5'd1, 5'd2, 5'd3, 16'h0, 26'h0, 0, 1'b0);
      vectors++;
      if (mem_wdata !== 32'h0022_1820) begin miscompares++; $display("FAIL add_word: got %h expected 00221820", mem_wdata); end
   endtask

   task automatic test_sequence();
      pulse_clear();
      do_req(5, 5'd0, 5'd8, 5'd0, 16'h0004, 26'h0, 0, 1'b0);
      vectors++;
      if (mem_wdata !== 32'h8C08_0004) begin miscompares++; $display("FAIL lw_word: got %h expected 8c080004", mem_wdata); end
      do_req(8, 5'd8, 5'd9, 5'd0, 16'hFFFE, 26'h0, 0, 1'b0);
      vectors++;
      if (mem_wdata !== 32'h1509_FFFE) begin miscompares++; $display("FAIL bne_word: got %h expected 1509fffe", mem_wdata); end
      do_req(11, 5'd0, 5'd0, 5'd0, 16'h0, 26'h000_0010, 0, 1'b0);
      vectors++;
      if (mem_wdata !== 32'h0800_0010) begin miscompares++; $display("FAIL j_word: got %h expected 08000010", mem_wdata); end
   endtask

   task automatic test_stall();
      do_req(9, 5'd4, 5'd5, 5'd0, 16'h1234, 26'h0, 3, 1'b0);
      do_req(3, 5'd7, 5'd6, 5'd31, 16'h0, 26'h0, 2, 1'b1);
   endtask

   task automatic test_illegal();
      do_req(13, 5'd1, 5'd1, 5'd1, 16'h1, 26'h1, 0, 1'b0);
      do_req(1, 5'd9, 5'd10, 5'd11, 16'h0, 26'h0, 1, 1'b0);
   endtask

   task automatic test_full();
      pulse_clear();
      in_kind = 4'd0; mem_ready = 1'b1;
      for (int i = 0; i < 2; i++) begin
         in_rd = 5'(i); in_valid = 1'b1;
         #1;
         vectors++;
         if (s_in_ready !== 1'b1) begin miscompares++; $display("FAIL full_ready_%0d: got %b expected 1", i, s_in_ready); end
         tick();
         in_valid = 1'b0;
         vectors++;
         if (s_mem_we !== 1'b1 || s_mem_addr !== 32'(i * 4)) begin miscompares++; $display("FAIL full_write_%0d: got %b/%h expected 1/%h", i, s_mem_we, s_mem_addr, i * 4); end
         tick();
         vectors++;
         if (s_count !== 8'(i + 1)) begin miscompares++; $display("FAIL full_count_%0d: got %0d expected %0d", i, s_count, i + 1); end
      end
      in_valid = 1'b1;
      #1;
      vectors += 2;
      if (s_full !== 1'b1) begin miscompares++; $display("FAIL full_flag: got %b expected 1", s_full); end
      if (s_in_ready !== 1'b0) begin miscompares++; $display("FAIL full_blocks: got %b expected 0", s_in_ready); end
      tick();
      in_valid = 1'b0;
      vectors++;
      if (s_mem_we !== 1'b0 || s_count !== 8'd2) begin miscompares++; $display("FAIL full_no_write: got %b/%0d expected 0/2", s_mem_we, s_count); end
      clear = 1'b1;
      tick();
      clear = 1'b0;
      vectors += 2;
      if (s_count !== 8'd0) begin miscompares++; $display("FAIL clear_count: got %0d expected 0", s_count); end
      if (s_full !== 1'b0) begin miscompares++; $display("FAIL clear_full: got %b expected 0", s_full); end
      in_valid = 1'b1;
      tick();
      in_valid = 1'b0;
      vectors++;
      if (s_mem_we !== 1'b1 || s_mem_addr !== 32'h0) begin miscompares++; $display("FAIL clear_next_addr: got %b/%h expected 1/0", s_mem_we, s_mem_addr); end
      tick();
      mem_ready = 1'b0;
      tick();
      tick();
      pulse_clear();
   endtask

   task automatic test_reset_send();
      in_kind = 4'd2; in_valid = 1'b1; mem_ready = 1'b0;
      tick();
      in_valid = 1'b0;
      vectors++;
      if (mem_we !== 1'b1) begin miscompares++; $display("FAIL rst_send_we: got %b expected 1", mem_we); end
      reset = 1'b0; mem_ready = 1'b1;
      tick();
      reset = 1'b1; mem_ready = 1'b0;
      exp_count = 0; exp_err = 1'b0;
      vectors += 3;
      if (mem_we !== 1'b0) begin miscompares++; $display("FAIL rst_abort_we: got %b expected 0", mem_we); end
      if (count !== 8'd0) begin miscompares++; $display("FAIL rst_abort_count: got %0d expected 0", count); end
      if (in_ready !== 1'b1) begin miscompares++; $display("FAIL rst_abort_idle: got %b expected 1", in_ready); end
   endtask

   task automatic test_random();
      pulse_clear();
      for (int n = 0; n < 60; n++) begin
         if ($urandom_range(7) == 0) begin
            pulse_clear();
            vectors += 3;
            if (count !== 8'd0) begin miscompares++; $display("FAIL rand_clear_count: got %0d expected 0", count); end
            if (err !== 1'b0) begin miscompares++; $display("FAIL rand_clear_err: got %b expected 0", err); end
            if (full !== 1'b0) begin miscompares++; $display("FAIL rand_clear_full: got %b expected 0", full); end
         end else
            do_req($urandom_range(15), 5'($urandom), 5'($urandom), 5'($urandom), 16'($urandom),
                   26'($urandom), $urandom_range(3), 1'($urandom));
      end
   endtask

   initial begin
      #500000;
      $display("FAIL watchdog: simulation did not finish in time");
      $fatal(1);
   end

   initial begin
      test_reset();
      test_add();
      test_sequence();
      test_stall();
      test_illegal();
      test_full();
      test_reset_send();
      test_random();
      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end
endmodule
